// File: rtl/sram_mem_controller_if.sv
// Bundle between the MEM stage, the SRAM controller and the board SRAM pins.
// mem_err is present only when MEM_ALIGN_CHECK_EN is defined.
interface sram_mem_controller_if #(
  parameter int SRAM_AW = 18
);
  logic               rd_en;
  logic               wr_en;
  logic [31:0]        address;
  logic [31:0]        write_data;
  logic [31:0]        read_data;
  logic               ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_out;
  logic [15:0]        sram_dq_in;
  logic               sram_dq_oe;
  logic               sram_we_n;
`ifdef MEM_ALIGN_CHECK_EN
  logic               mem_err;
`endif

  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
`ifdef MEM_ALIGN_CHECK_EN
    , output mem_err
`endif
  );

  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
`ifdef MEM_ALIGN_CHECK_EN
    , input mem_err
`endif
  );
endinterface

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit load/store into two 16-bit async-SRAM accesses, freezing the pipeline via ready.
// Optional alignment/range checking with a mem_err output is enabled by defining MEM_ALIGN_CHECK_EN.
module sram_mem_controller #(
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  sram_mem_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam int         IDX_W = SRAM_AW - 1;
  localparam logic [3:0] LAST  = 4'(WAIT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               op_wr_q, op_wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        read_data_q, read_data_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic               oe_q, oe_d;
  logic               we_n_q, we_n_d;
`ifdef MEM_ALIGN_CHECK_EN
  logic               mem_err_q, mem_err_d;
`endif

  logic [31:0] offset;
  logic        req;
  logic        bad_req;
  logic        last;
  logic        unused_offset_bits;

  function automatic logic [SRAM_AW-1:0] half_addr(input logic [IDX_W-1:0] idx,
                                                   input logic hi);
    return {idx, hi};
  endfunction

  function automatic logic [15:0] half_data(input logic [31:0] word, input logic hi);
    return hi ? word[31:16] : word[15:0];
  endfunction

  assign offset  = bus.address - ADDR_BASE;
  assign req     = bus.rd_en | bus.wr_en;
  assign last    = (cnt_q == LAST);
  // Bits above the SRAM capacity are dropped on purpose so large addresses alias.
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
  assign bad_req = (bus.address[1:0] != 2'b00) || (bus.address < ADDR_BASE);
`else
  assign bad_req = 1'b0;
`endif

  // Nothing is in flight while reset is held, so the pipeline is never frozen by it.
  assign bus.ready = ~rst | (state_q == DONE) | ((state_q == IDLE) & ~req);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    oe_d        = oe_q;
    we_n_d      = we_n_q;
`ifdef MEM_ALIGN_CHECK_EN
    mem_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          op_wr_d = bus.wr_en;
          idx_d   = offset[SRAM_AW:2];
          wdata_d = bus.write_data;
          cnt_d   = 4'd0;
          if (bad_req) begin
            state_d = DONE;
`ifdef MEM_ALIGN_CHECK_EN
            mem_err_d = 1'b1;
`endif
          end else begin
            // Bus outputs are set up one cycle early so they are registered during LOW.
            state_d     = LOW;
            sram_addr_d = half_addr(offset[SRAM_AW:2], 1'b0);
            dq_out_d    = bus.wr_en ? half_data(bus.write_data, 1'b0) : 16'h0000;
            oe_d        = bus.wr_en;
            we_n_d      = ~bus.wr_en;
          end
        end
      end
      LOW: begin
        if (last) begin
          if (!op_wr_q) read_data_d[15:0] = bus.sram_dq_in;
          state_d     = HIGH;
          cnt_d       = 4'd0;
          sram_addr_d = half_addr(idx_q, 1'b1);
          dq_out_d    = op_wr_q ? half_data(wdata_q, 1'b1) : 16'h0000;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HIGH: begin
        if (last) begin
          if (!op_wr_q) read_data_d[31:16] = bus.sram_dq_in;
          state_d     = DONE;
          cnt_d       = 4'd0;
          sram_addr_d = '0;
          dq_out_d    = 16'h0000;
          oe_d        = 1'b0;
          we_n_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      op_wr_q     <= 1'b0;
      read_data_q <= 32'h0;
      sram_addr_q <= '0;
      dq_out_q    <= 16'h0000;
      oe_q        <= 1'b0;
      we_n_q      <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
      mem_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      oe_q        <= oe_d;
      we_n_q      <= we_n_d;
`ifdef MEM_ALIGN_CHECK_EN
      mem_err_q   <= mem_err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

  assign bus.read_data   = read_data_q;
  assign bus.sram_addr   = sram_addr_q;
  assign bus.sram_dq_out = dq_out_q;
  assign bus.sram_dq_oe  = oe_q;
  assign bus.sram_we_n   = we_n_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign bus.mem_err     = mem_err_q;
`endif

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
Responder for the MEM-stage memory control signals (mem_read/mem_write) that the instruction decoder produces. It turns one 32-bit load or store into two 16-bit accesses on an external asynchronous SRAM. While an access is in flight it drops ready, and the pipeline freezes on ~ready. It sits between the MEM stage and the board SRAM pins.

Parameters:
ADDR_BASE, 1024, CPU byte address that maps to SRAM halfword 0.
SRAM_AW, 18, SRAM halfword address width.
WAIT_CYCLES, 2, cycles each halfword is held on the SRAM bus; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
rd_en  in  1  load request (mem_read from MEM stage).
wr_en  in  1  store request (mem_write from MEM stage).
address  in  32  CPU byte address (ALU result).
write_data  in  32  store data (Rm value).
read_data  out  32  load result.
ready  out  1  access complete / idle; pipeline freeze = ~ready.
sram_addr  out  SRAM_AW  SRAM halfword address.
sram_dq_out  out  16  write data to SRAM.
sram_dq_in  in  16  read data from SRAM.
sram_dq_oe  out  1  1 = drive sram_dq_out onto the pad.
sram_we_n  out  1  SRAM write enable, active-low.

Behaviour:
- States: IDLE, LOW, HIGH, DONE. Counter cnt has 4 bits.
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
- ready is combinational:
  - 1 in DONE.
  - 1 in IDLE when rd_en=0 and wr_en=0.
  - 0 otherwise. A request arriving in IDLE drops ready in that same cycle.
- IDLE with rd_en or wr_en:
  - Latch op, word index = (address - ADDR_BASE)[SRAM_AW:2], and write_data.
  - Go to LOW, cnt=0.
  - Write wins when both enables are high; read_data is then unchanged.
- LOW, WAIT_CYCLES cycles:
  - sram_addr = {word_index, 1'b0}, truncated to SRAM_AW.
  - Write: sram_we_n=0, sram_dq_oe=1, sram_dq_out = write_data[15:0].
  - Read: sram_we_n=1, sram_dq_oe=0; on the last cycle capture sram_dq_in into read_data[15:0].
  - Then go to HIGH, cnt=0.
- HIGH: same as LOW with address {word_index, 1'b1} and bits [31:16].
- DONE: ready=1 for exactly one cycle; SRAM outputs return to idle values; next state is IDLE.
- Latency: ready is low for 1 + 2*WAIT_CYCLES cycles, then high for the DONE cycle. With WAIT_CYCLES=2: 5 cycles low, 6th cycle high.
- The pipeline holds rd_en, wr_en, address and write_data stable while ready=0. Inputs are only sampled in IDLE; changes in other states are ignored.
- Back-to-back requests: a request seen in IDLE right after DONE is a new transaction. There is no idle gap beyond the IDLE sampling cycle.
- read_data holds its last completed load value until the next read's halves are captured. The low half updates at the end of LOW and the high half at the end of HIGH. The full new value is valid in DONE.
- sram_we_n is driven from registered state and has no combinational glitch path from the request inputs.
- Address wrap: word_index bits above SRAM_AW-1 are discarded, so an address beyond SRAM capacity aliases.
- Reset mid-access aborts immediately: sram_we_n=1 asynchronously and the partial write is not completed. read_data returns to 0.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- When defined, add output mem_err (1 bit, reset 0).
- A request with address[1:0] != 0 or address < ADDR_BASE goes IDLE -> DONE directly:
  - no SRAM cycle; sram_we_n stays 1;
  - read_data is unchanged;
  - ready is low for exactly 1 cycle;
  - mem_err=1 during the DONE cycle only.
- When not defined, there is no mem_err port, address[1:0] is ignored, and addresses below ADDR_BASE wrap modulo 2^32.

Test Plan:
- Reset: hold rst=0 with requests active -> ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0.
- Store, WAIT_CYCLES=2: wr_en=1, address=1028, write_data=32'hDEADBEEF. Required response:
  - sram_addr=2 with dq_out=16'hBEEF and we_n=0 for 2 cycles;
  - then sram_addr=3 with dq_out=16'hDEAD for 2 cycles;
  - ready=0 for 5 cycles, then 1.
- Load from the SRAM model after the store above: rd_en=1, address=1028 -> read_data=32'hDEADBEEF in the DONE cycle, sram_we_n=1 throughout.
- Back-to-back store then load with no gap: ready shows exactly one high cycle between the two 5-cycle busy windows, and the load returns the stored value.
- Reset mid-store: assert rst=0 in the HIGH phase -> sram_we_n=1 within the same cycle, state=IDLE, SRAM word upper half not written.
- MEM_ALIGN_CHECK_EN: rd_en=1, address=1030 -> ready low for 1 cycle, mem_err=1 for 1 cycle, no SRAM activity, read_data unchanged.
